stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Hardware stack engine that sits directly upstream of the 64KB data RAM. It owns the stack pointer (SP) and turns CPU push/pop requests into byte-wide RAM accesses in the stack page 0x0100-0x01FF.
- Supports 8-bit and 16-bit push/pop with overflow and underflow detection.
- Drives the RAM's addr, data_in, write_enable and read_enable. Captures the RAM's asynchronous data_out.

Parameters:
- STACK_PAGE, 8'h01, high address byte of the stack page.
- SP_RESET, 8'hFF, SP value after reset (empty stack).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- push_req  in  1  push request; sampled only in IDLE
- pop_req  in  1  pop request; sampled only in IDLE
- wide  in  1  1 = 16-bit operation, 0 = 8-bit; sampled with the request
- push_data  in  16  data to push; byte push uses [7:0]
- sp_load  in  1  load SP from sp_in; sampled only in IDLE
- sp_in  in  8  new SP value
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: 1 = request rejected (overflow, underflow or conflict)
- pop_data  out  16  popped value; byte pop zero-extends; held until the next successful pop
- sp  out  8  current stack pointer
- ram_addr  out  16  {STACK_PAGE, byte address} during an access, else 16'h0000
- ram_wdata  out  8  write byte during a push access, else 8'h00
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- ram_rdata  in  8  RAM data_out (combinational read)

Behaviour:
- Reset (synchronous, active-high): state=IDLE, sp=SP_RESET, depth=8'hFF-SP_RESET (9-bit counter, range 0..256), pop_data=0. done, err, ram_we and ram_re are 0.
- Reset mid-operation aborts the operation. RAM writes already issued stay in RAM. No done pulse.
- Stack model: full-descending. A push writes at SP, then SP decrements. A pop increments SP, then reads. SP is 8-bit and wraps mod 256; depth is the authority for full/empty.
- States: IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, DONE.
- Request priority in IDLE:
  1. sp_load: sp<=sp_in, depth<=255-sp_in. Takes one edge; no done pulse; stays IDLE.
  2. push_req and pop_req both high: go to DONE with err=1.
  3. push_req: needs depth+n <= 256, where n=2 if wide else 1. Otherwise go to DONE with err=1. No RAM access and SP unchanged on any error.
  4. pop_req: needs depth >= n, otherwise go to DONE with err=1.
- Word push: PUSH_HI writes push_data[15:8] at SP, then PUSH_LO writes push_data[7:0] at SP-1, then DONE.
- Byte push: PUSH_LO only.
- Word pop: POP_LO reads SP+1 into pop_data[7:0], then POP_HI reads SP+2 into pop_data[15:8], then DONE.
- Byte pop: POP_LO only, and pop_data[15:8]<=0.
- Each access state lasts exactly one cycle:
  - ram_we or ram_re is high only in that cycle.
  - ram_rdata is captured on the closing edge.
  - sp and depth update on that same edge (push: sp-1, depth+1; pop: sp+1, depth-1).
- DONE lasts one cycle with done=1 and err as decided at acceptance, then returns to IDLE.
- Latency from the accepting edge to done high:
  - byte op: 2 cycles
  - word op: 3 cycles
  - rejected request: 1 cycle
- Requests arriving while busy are ignored and are not queued. The requester holds or re-issues them.
- ram_we and ram_re are never high together.

Decomposition:
- Shared include (cpu_defs): STACK_PAGE default, state encodings (3-bit localparams), width constants.
- No sub-module. The FSM, SP/depth registers and address mux are a single module.

Test Plan:
- Reset, then byte push 0xA5: one cycle with ram_we=1, ram_addr=0x01FF, ram_wdata=0xA5. Then done=1, err=0, sp=0xFE.
- Word push 0x1234 from empty: writes 0x01FF=0x12 then 0x01FE=0x34, sp=0xFD. A following word pop reads 0x01FE then 0x01FF, giving pop_data=0x1234 and sp=0xFF.
- Pop at reset (empty): done=1, err=1, one cycle after acceptance. No ram_re. sp stays 0xFF.
- sp_load 0x00 (depth 255):
  - Word push: err=1, no write.
  - Byte push 0x5A: writes 0x0100, sp wraps to 0xFF, depth 256.
  - Another byte push: err=1.
- push_req and pop_req high together in IDLE: done+err after one cycle, no RAM access, sp unchanged.
- Word push 0xBEEF from empty, with reset asserted during PUSH_LO: next cycle state=IDLE, sp=0xFF, no done, RAM 0x01FF=0xBE.

Source files
------------

// File: rtl/stack_unit_pkg.sv
// Shared definitions for the hardware stack engine:
// page/reset defaults, state encodings and datapath widths.
package stack_unit_pkg;

    localparam logic [7:0] STACK_PAGE_DEF = 8'h01;
    localparam logic [7:0] SP_RESET_DEF   = 8'hFF;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int DEPTH_W = 9;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_PUSH_HI = 3'd1;
    localparam state_t S_PUSH_LO = 3'd2;
    localparam state_t S_POP_LO  = 3'd3;
    localparam state_t S_POP_HI  = 3'd4;
    localparam state_t S_DONE    = 3'd5;

endpackage

// File: rtl/stack_unit.sv
// Stack engine: owns SP and depth, turns push/pop requests into
// byte-wide accesses on the stack page of the data RAM.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEF,
    parameter logic [7:0] SP_RESET   = SP_RESET_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_req,
    input  logic                pop_req,
    input  logic                wide,
    input  logic [WORD_W-1:0]   push_data,
    input  logic                sp_load,
    input  logic [BYTE_W-1:0]   sp_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [WORD_W-1:0]   pop_data,
    output logic [BYTE_W-1:0]   sp,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [BYTE_W-1:0]   ram_wdata,
    output logic                ram_we,
    output logic                ram_re,
    input  logic [BYTE_W-1:0]   ram_rdata
);

    localparam logic [DEPTH_W-1:0] DEPTH_RESET = {1'b0, 8'hFF - SP_RESET};

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   sp_q, sp_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [WORD_W-1:0]   pop_data_q, pop_data_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                wide_q, wide_d;

    logic [BYTE_W-1:0]   sp_inc;
    logic [9:0]          need;
    logic [9:0]          depth_ext;

    assign sp_inc    = sp_q + 8'd1;
    assign need      = wide ? 10'd2 : 10'd1;
    assign depth_ext = {1'b0, depth_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sp_q       <= SP_RESET;
            depth_q    <= DEPTH_RESET;
            pop_data_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            wide_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            depth_q    <= depth_d;
            pop_data_q <= pop_data_d;
            data_q     <= data_d;
            err_q      <= err_d;
            wide_q     <= wide_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        depth_d    = depth_q;
        pop_data_d = pop_data_q;
        data_d     = data_q;
        err_d      = err_q;
        wide_d     = wide_q;
        case (state_q)
            S_IDLE: begin
                if (sp_load) begin
                    sp_d    = sp_in;
                    depth_d = {1'b0, 8'hFF - sp_in};
                end else if (push_req && pop_req) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (push_req) begin
                    wide_d = wide;
                    data_d = push_data;
                    if (depth_ext + need <= 10'd256) begin
                        state_d = wide ? S_PUSH_HI : S_PUSH_LO;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end else if (pop_req) begin
                    wide_d = wide;
                    if (depth_ext >= need) begin
                        state_d = S_POP_LO;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_PUSH_HI: begin
                sp_d    = sp_q - 8'd1;
                depth_d = depth_q + 9'd1;
                state_d = S_PUSH_LO;
            end
            S_PUSH_LO: begin
                sp_d    = sp_q - 8'd1;
                depth_d = depth_q + 9'd1;
                state_d = S_DONE;
            end
            S_POP_LO: begin
                sp_d       = sp_inc;
                depth_d    = depth_q - 9'd1;
                // A word pop fills the high byte on the following access
                pop_data_d = {wide_q ? pop_data_q[15:8] : 8'h00, ram_rdata};
                state_d    = wide_q ? S_POP_HI : S_DONE;
            end
            S_POP_HI: begin
                sp_d       = sp_inc;
                depth_d    = depth_q - 9'd1;
                pop_data_d = {ram_rdata, pop_data_q[7:0]};
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state_q)
            S_PUSH_HI: begin
                ram_addr  = {STACK_PAGE, sp_q};
                ram_wdata = data_q[15:8];
                ram_we    = 1'b1;
            end
            S_PUSH_LO: begin
                ram_addr  = {STACK_PAGE, sp_q};
                ram_wdata = data_q[7:0];
                ram_we    = 1'b1;
            end
            S_POP_LO, S_POP_HI: begin
                ram_addr = {STACK_PAGE, sp_inc};
                ram_re   = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign pop_data = pop_data_q;
    assign sp       = sp_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a behavioural stack model queues
// expected RAM accesses and completions; monitors pop and compare them.
module tb_stack_unit;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    typedef struct packed {
        logic        err;
        logic [15:0] pd;
        logic [7:0]  sp;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push_req = 1'b0;
    logic        pop_req = 1'b0;
    logic        wide = 1'b0;
    logic [15:0] push_data = '0;
    logic        sp_load = 1'b0;
    logic [7:0]  sp_in = '0;
    logic        busy, done, err;
    logic [15:0] pop_data;
    logic [7:0]  sp;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we, ram_re;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:65535];
    logic [7:0]  sm  [0:255];
    logic [7:0]  m_sp;
    int          m_depth;
    logic [15:0] m_pd;

    acc_t acc_q[$];
    res_t res_q[$];

    int checks = 0;
    int passes = 0;

    stack_unit dut (
        .clk(clk), .reset(reset),
        .push_req(push_req), .pop_req(pop_req), .wide(wide),
        .push_data(push_data), .sp_load(sp_load), .sp_in(sp_in),
        .busy(busy), .done(done), .err(err), .pop_data(pop_data),
        .sp(sp), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    // RAM-side and completion monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (ram_we || ram_re) begin
                acc_t a;
                checks++;
                if (ram_we && ram_re) begin
                    $display("FAIL we_re_both: both enables high at %0t", $time);
                end else if (acc_q.size() == 0) begin
                    $display("FAIL access_unexp: addr=%h we=%b re=%b, none expected",
                             ram_addr, ram_we, ram_re);
                end else begin
                    a = acc_q.pop_front();
                    if (ram_we !== a.we || ram_addr !== a.addr ||
                        (a.we && ram_wdata !== a.data))
                        $display("FAIL access: got we=%b addr=%h wd=%h, need we=%b addr=%h wd=%h",
                                 ram_we, ram_addr, ram_wdata, a.we, a.addr, a.data);
                    else
                        passes++;
                end
            end
            if (done) begin
                res_t r;
                checks++;
                if (res_q.size() == 0) begin
                    $display("FAIL done_unexp: done with no expected result");
                end else begin
                    r = res_q.pop_front();
                    if (err !== r.err || pop_data !== r.pd || sp !== r.sp)
                        $display("FAIL result: got err=%b pd=%h sp=%h, need err=%b pd=%h sp=%h",
                                 err, pop_data, sp, r.err, r.pd, r.sp);
                    else
                        passes++;
                end
            end
        end
    end

    task automatic model_op(input bit pu, input bit po, input bit w,
                            input logic [15:0] d, output int lat);
        int   n;
        res_t r;
        n     = w ? 2 : 1;
        r.err = 1'b0;
        lat   = 1;
        if (pu && po) begin
            r.err = 1'b1;
        end else if (pu) begin
            if (m_depth + n > 256) begin
                r.err = 1'b1;
            end else begin
                if (w) begin
                    acc_q.push_back({1'b1, 8'h01, m_sp, d[15:8]});
                    sm[m_sp] = d[15:8];
                    m_sp--;
                    m_depth++;
                end
                acc_q.push_back({1'b1, 8'h01, m_sp, d[7:0]});
                sm[m_sp] = d[7:0];
                m_sp--;
                m_depth++;
                lat = n + 1;
            end
        end else if (po) begin
            if (m_depth < n) begin
                r.err = 1'b1;
            end else begin
                m_sp++;
                acc_q.push_back({1'b0, 8'h01, m_sp, 8'h00});
                m_pd = {8'h00, sm[m_sp]};
                m_depth--;
                if (w) begin
                    m_sp++;
                    acc_q.push_back({1'b0, 8'h01, m_sp, 8'h00});
                    m_pd[15:8] = sm[m_sp];
                    m_depth--;
                end
                lat = n + 1;
            end
        end
        r.pd = m_pd;
        r.sp = m_sp;
        res_q.push_back(r);
    endtask

    // Drive one request for one edge, then count cycles to done (-1 = timeout)
    task automatic do_op(input bit pu, input bit po, input bit w,
                         input logic [15:0] d, output int exp_lat, output int lat);
        model_op(pu, po, w, d, exp_lat);
        push_req  = pu;
        pop_req   = po;
        wide      = w;
        push_data = d;
        @(posedge clk);
        #1;
        push_req = 1'b0;
        pop_req  = 1'b0;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        m_sp    = 8'hFF;
        m_depth = 0;
        m_pd    = 16'h0000;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (sp !== 8'hFF || busy !== 1'b0 || pop_data !== 16'h0)
            $display("FAIL reset_regs: sp=%h busy=%b pd=%h, need FF 0 0000", sp, busy, pop_data);
        else passes++;
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0)
            $display("FAIL reset_outs: done=%b err=%b we=%b re=%b, need all 0",
                     done, err, ram_we, ram_re);
        else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_byte_push();
        int e, l;
        do_op(1'b1, 1'b0, 1'b0, 16'h00A5, e, l);
        checks++;
        if (l !== 2 || sp !== 8'hFE)
            $display("FAIL byte_push: lat=%0d sp=%h, need 2 FE", l, sp);
        else passes++;
    endtask

    task automatic test_word_push_pop();
        int e, l;
        apply_reset();
        do_op(1'b1, 1'b0, 1'b1, 16'h1234, e, l);
        checks++;
        if (l !== 3 || sp !== 8'hFD)
            $display("FAIL word_push: lat=%0d sp=%h, need 3 FD", l, sp);
        else passes++;
        do_op(1'b0, 1'b1, 1'b1, 16'h0000, e, l);
        checks++;
        if (l !== 3 || sp !== 8'hFF || pop_data !== 16'h1234)
            $display("FAIL word_pop: lat=%0d sp=%h pd=%h, need 3 FF 1234", l, sp, pop_data);
        else passes++;
    endtask

    task automatic test_pop_empty();
        int e, l;
        apply_reset();
        do_op(1'b0, 1'b1, 1'b0, 16'h0000, e, l);
        checks++;
        if (l !== 1 || sp !== 8'hFF)
            $display("FAIL pop_empty: lat=%0d sp=%h, need 1 FF", l, sp);
        else passes++;
    endtask

    task automatic test_sp_load_boundary();
        int e, l;
        apply_reset();
        sp_load = 1'b1;
        sp_in   = 8'h00;
        @(posedge clk);
        #1;
        sp_load = 1'b0;
        m_sp    = 8'h00;
        m_depth = 255;
        @(negedge clk);
        checks++;
        if (sp !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL sp_load: sp=%h busy=%b done=%b, need 00 0 0", sp, busy, done);
        else passes++;
        @(posedge clk);
        #1;
        do_op(1'b1, 1'b0, 1'b1, 16'hCAFE, e, l);
        checks++;
        if (l !== 1 || sp !== 8'h00)
            $display("FAIL full_word_push: lat=%0d sp=%h, need 1 00", l, sp);
        else passes++;
        do_op(1'b1, 1'b0, 1'b0, 16'h005A, e, l);
        checks++;
        if (l !== 2 || sp !== 8'hFF || mem[16'h0100] !== 8'h5A)
            $display("FAIL last_byte_push: lat=%0d sp=%h mem=%h, need 2 FF 5A",
                     l, sp, mem[16'h0100]);
        else passes++;
        do_op(1'b1, 1'b0, 1'b0, 16'h0077, e, l);
        checks++;
        if (l !== 1 || sp !== 8'hFF)
            $display("FAIL overflow_push: lat=%0d sp=%h, need 1 FF", l, sp);
        else passes++;
        do_op(1'b0, 1'b1, 1'b0, 16'h0000, e, l);
        checks++;
        if (l !== 2 || sp !== 8'h00 || pop_data !== 16'h005A)
            $display("FAIL wrap_pop: lat=%0d sp=%h pd=%h, need 2 00 005A", l, sp, pop_data);
        else passes++;
    endtask

    task automatic test_conflict();
        int e, l;
        logic [7:0] s0;
        apply_reset();
        do_op(1'b1, 1'b0, 1'b0, 16'h0011, e, l);
        s0 = sp;
        do_op(1'b1, 1'b1, 1'b1, 16'h2222, e, l);
        checks++;
        if (l !== 1 || sp !== s0)
            $display("FAIL conflict: lat=%0d sp=%h, need 1 %h", l, sp, s0);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int e, l, k;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 3);
            do_op(k < 2, k >= 2, k[0], 16'($urandom), e, l);
            checks++;
            if (l !== e || sp !== m_sp)
                $display("FAIL b2b_%0d: lat=%0d sp=%h, need %0d %h", i, l, sp, e, m_sp);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        apply_reset();
        push_req  = 1'b1;
        wide      = 1'b1;
        push_data = 16'hBEEF;
        acc_q.push_back({1'b1, 16'h01FF, 8'hBE});
        @(posedge clk);
        #1;
        push_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sp !== 8'hFF || mem[16'h01FF] !== 8'hBE)
            $display("FAIL reset_mid: busy=%b sp=%h mem=%h, need 0 FF BE",
                     busy, sp, mem[16'h01FF]);
        else passes++;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0)
            $display("FAIL reset_mid_done: done seen %0d times, need 0", seen);
        else passes++;
        m_sp    = 8'hFF;
        m_depth = 0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) sm[i] = 8'h00;
        test_reset();
        test_byte_push();
        test_word_push_pop();
        test_pop_empty();
        test_sp_load_boundary();
        test_conflict();
        test_back_to_back();
        test_reset_mid_op();
        checks++;
        if (acc_q.size() != 0 || res_q.size() != 0)
            $display("FAIL drain: %0d accesses, %0d results left, need 0 0",
                     acc_q.size(), res_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
